// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program counter and instruction register sequencer with a RUN/HALT state
// machine. While running, the sequencer loads instructions into IR on the
// IL strobe, advances or jumps the PC as selected by PS, and counts the
// loaded instructions (saturating). An EOE request freezes everything in
// HALT until reset.
//
// Ports
//   clk         system clock, all updates on the rising edge
//   reset       synchronous active-high reset
//   PS[1:0]     PC select: 0 hold, 1 increment, 2 relative jump, 3 absolute jump
//   BC[1:0]     branch condition: 0 zero, 1 not-zero, 2 negative, 3 always
//   IL          instruction load strobe
//   EOE         end-of-execution request
//   zero, neg   ALU flags used by the branch condition
//   instrIn     instruction memory read data at address PC
//   absTarget   register-file value used for absolute jumps
//   PC          program counter / instruction memory address
//   IR          instruction register
//   opcode, Rd  IR[15:12] and IR[11:8]
//   pcLink      PC+1 (link value for JAL)
//   halted      high once end of execution has been accepted
//   instrCount  instructions loaded since reset, saturating at 16'hFFFF
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PS,
  input  logic [1:0]  BC,
  input  logic        IL,
  input  logic        EOE,
  input  logic        zero,
  input  logic        neg,
  input  logic [15:0] instrIn,
  input  logic [7:0]  absTarget,
  output logic [7:0]  PC,
  output logic [15:0] IR,
  output logic [3:0]  opcode,
  output logic [3:0]  Rd,
  output logic [7:0]  pcLink,
  output logic        halted,
  output logic [15:0] instrCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  pcNext;
  logic [15:0] irNext;
  logic [15:0] countNext;
  logic        taken;

  // State register; reset wins over every other input, including in HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      PC         <= 8'h00;
      IR         <= 16'h0000;
      instrCount <= 16'h0000;
    end else begin
      state      <= stateNext;
      PC         <= pcNext;
      IR         <= irNext;
      instrCount <= countNext;
    end
  end

  // Branch condition evaluation from the current ALU flags.
  always_comb begin
    taken = 1'b0;
    unique case (BC)
      2'd0: taken = zero;
      2'd1: taken = ~zero;
      2'd2: taken = neg;
      2'd3: taken = 1'b1;
    endcase
  end

  // Next-state logic. The relative offset is the low byte of the IR already
  // held in the register, so a load on the same edge never affects the jump.
  // An 8-bit add of IR[7:0] is the same as adding its sign extension modulo 256.
  always_comb begin
    stateNext = state;
    pcNext    = PC;
    irNext    = IR;
    countNext = instrCount;
    if (state == RUN) begin
      if (EOE) begin
        stateNext = HALT;
      end else begin
        if (IL) begin
          irNext = instrIn;
          if (instrCount != 16'hFFFF) begin
            countNext = instrCount + 16'd1;
          end
        end
        unique case (PS)
          2'd0: pcNext = PC;
          2'd1: pcNext = PC + 8'd1;
          2'd2: pcNext = taken ? (PC + IR[7:0]) : (PC + 8'd1);
          2'd3: pcNext = absTarget;
        endcase
      end
    end
  end

  // Outputs derived only from registers, so no input reaches them combinationally.
  assign opcode = IR[15:12];
  assign Rd     = IR[11:8];
  assign pcLink = PC + 8'd1;
  assign halted = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer: a table of per-cycle vectors with
// hand-computed expected register values, followed by hand-written
// sequences for halting, reset recovery and counter saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PS;
  logic [1:0]  BC;
  logic        IL;
  logic        EOE;
  logic        zero;
  logic        neg;
  logic [15:0] instrIn;
  logic [7:0]  absTarget;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic [3:0]  opcode;
  logic [3:0]  Rd;
  logic [7:0]  pcLink;
  logic        halted;
  logic [15:0] instrCount;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        reset;
    logic [1:0]  ps;
    logic [1:0]  bc;
    logic        il;
    logic        eoe;
    logic        zero;
    logic        neg;
    logic [15:0] instrIn;
    logic [7:0]  absTarget;
    logic [7:0]  expPc;
    logic [15:0] expIr;
    logic [15:0] expCount;
    logic        expHalted;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  pc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .PS(PS),
    .BC(BC),
    .IL(IL),
    .EOE(EOE),
    .zero(zero),
    .neg(neg),
    .instrIn(instrIn),
    .absTarget(absTarget),
    .PC(PC),
    .IR(IR),
    .opcode(opcode),
    .Rd(Rd),
    .pcLink(pcLink),
    .halted(halted),
    .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [1:0] ps, input logic [1:0] bc,
                              input logic il, input logic eoe, input logic z, input logic n,
                              input logic [15:0] ins, input logic [7:0] abst,
                              input logic [7:0] ePc, input logic [15:0] eIr,
                              input logic [15:0] eCnt, input logic eHalt);
    vec_t v;
    v.reset = r; v.ps = ps; v.bc = bc; v.il = il; v.eoe = eoe; v.zero = z; v.neg = n;
    v.instrIn = ins; v.absTarget = abst;
    v.expPc = ePc; v.expIr = eIr; v.expCount = eCnt; v.expHalted = eHalt;
    return v;
  endfunction

  // Drive one vector away from the active edge, then let one rising edge pass.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset     = v.reset;
    PS        = v.ps;
    BC        = v.bc;
    IL        = v.il;
    EOE       = v.eoe;
    zero      = v.zero;
    neg       = v.neg;
    instrIn   = v.instrIn;
    absTarget = v.absTarget;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input int tag, input logic [15:0] got,
                            input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, tag, got, exp);
    end
  endtask

  // Compare every output against the expected register values of a vector.
  task automatic checkOutput(input vec_t v, input int tag);
    logic [7:0] expLink;
    expLink = v.expPc + 8'd1;
    checkField("PC", tag, {8'h00, PC}, {8'h00, v.expPc});
    checkField("IR", tag, IR, v.expIr);
    checkField("instrCount", tag, instrCount, v.expCount);
    checkField("halted", tag, {15'h0, halted}, {15'h0, v.expHalted});
    checkField("opcode", tag, {12'h0, opcode}, {12'h0, v.expIr[15:12]});
    checkField("Rd", tag, {12'h0, Rd}, {12'h0, v.expIr[11:8]});
    checkField("pcLink", tag, {8'h00, pcLink}, {8'h00, expLink});
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; PS = 2'd0; BC = 2'd0; IL = 1'b0; EOE = 1'b0;
    zero = 1'b0; neg = 1'b0; instrIn = 16'h0; absTarget = 8'h0;

    //                 rst  PS    BC    IL    EOE   z     n     instrIn    abs     PC     IR         cnt       halt
    vecs[0]  = mk(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h00, 16'h0000, 16'd0, 1'b0);
    // Alternate load and increment: first fetch happens at address 0.
    vecs[1]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h00, 16'h0123, 16'd1, 1'b0);
    vecs[2]  = mk(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h01, 16'h0123, 16'd1, 1'b0);
    vecs[3]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h01, 16'h0123, 16'd2, 1'b0);
    vecs[4]  = mk(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h02, 16'h0123, 16'd2, 1'b0);
    vecs[5]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h02, 16'h0123, 16'd3, 1'b0);
    vecs[6]  = mk(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h03, 16'h0123, 16'd3, 1'b0);
    vecs[7]  = mk(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h03, 16'h0123, 16'd4, 1'b0);
    vecs[8]  = mk(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123, 8'h00, 8'h04, 16'h0123, 16'd4, 1'b0);
    // Load B0FD and jump absolute to 10 on the same edge.
    vecs[9]  = mk(1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hB0FD, 8'h10, 8'h10, 16'hB0FD, 16'd5, 1'b0);
    // Relative jumps with offset -3 under each branch condition.
    vecs[10] = mk(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h0D, 16'hB0FD, 16'd5, 1'b0);
    vecs[11] = mk(1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h10, 8'h10, 16'hB0FD, 16'd5, 1'b0);
    vecs[12] = mk(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h11, 16'hB0FD, 16'd5, 1'b0);
    vecs[13] = mk(1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h0E, 16'hB0FD, 16'd5, 1'b0);
    vecs[14] = mk(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h0F, 16'hB0FD, 16'd5, 1'b0);
    vecs[15] = mk(1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 8'h0C, 16'hB0FD, 16'd5, 1'b0);
    vecs[16] = mk(1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h09, 16'hB0FD, 16'd5, 1'b0);
    // Increment wrap FF -> 00, then absolute jump to 42.
    vecs[17] = mk(1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF, 8'hFF, 16'hB0FD, 16'd5, 1'b0);
    vecs[18] = mk(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, 16'hB0FD, 16'd5, 1'b0);
    vecs[19] = mk(1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h42, 8'h42, 16'hB0FD, 16'd5, 1'b0);
    // 02 + FC wraps to FE; absolute jump ignores a false branch condition.
    vecs[20] = mk(1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h20FC, 8'h02, 8'h02, 16'h20FC, 16'd6, 1'b0);
    vecs[21] = mk(1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFE, 16'h20FC, 16'd6, 1'b0);
    vecs[22] = mk(1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 8'h05, 16'h20FC, 16'd6, 1'b0);
    // Load and relative jump together: offset is the old IR (FC), not instrIn (01).
    vecs[23] = mk(1'b0, 2'd2, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 8'h00, 8'h01, 16'h3001, 16'd7, 1'b0);
    vecs[24] = mk(1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h05, 8'h05, 16'h3001, 16'd7, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // EOE with PS and IL active at PC 05: nothing moves, halted rises.
    v = mk(1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h77, 8'h05, 16'h3001, 16'd7, 1'b1);
    applyStimulus(v);
    checkOutput(v, 100);

    // Ten more pulses of every kind while halted cause no change.
    for (int i = 0; i < 10; i++) begin
      v = mk(1'b0, 2'(i % 4), 2'd3, 1'b1, i[0], 1'b1, 1'b1, 16'hA5A5, 8'h99,
             8'h05, 16'h3001, 16'd7, 1'b1);
      applyStimulus(v);
      checkOutput(v, 110 + i);
    end

    // Reset while halted.
    v = mk(1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 8'h00, 8'h00, 16'h0000, 16'd0, 1'b0);
    applyStimulus(v);
    checkOutput(v, 200);

    // Run to PC 20, then reset in the middle of a taken relative jump with a load.
    v = mk(1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 8'h20, 8'h20, 16'hABCD, 16'd1, 1'b0);
    applyStimulus(v);
    checkOutput(v, 201);
    v = mk(1'b1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 8'h33, 8'h00, 16'h0000, 16'd0, 1'b0);
    applyStimulus(v);
    checkOutput(v, 202);

    // Saturation: hold IL high long enough to reach FFFF, then load once more.
    @(negedge clk);
    reset = 1'b0; PS = 2'd0; BC = 2'd0; IL = 1'b1; EOE = 1'b0; instrIn = 16'h7E01;
    repeat (65534) @(posedge clk);
    #1;
    checkField("instrCount near saturation", 300, instrCount, 16'hFFFE);
    @(posedge clk);
    #1;
    checkField("instrCount at saturation", 301, instrCount, 16'hFFFF);
    @(posedge clk);
    #1;
    checkField("instrCount saturated hold", 302, instrCount, 16'hFFFF);
    checkField("PC during saturation run", 303, {8'h00, PC}, 16'h0000);
    checkField("IR during saturation run", 304, IR, 16'h7E01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
